// File: rtl/rename_pkg.sv
// Shared types and default sizing for the register-rename map unit.
package rename_pkg;

    localparam int unsigned NUM_ARCH_REGS_DEF = 32;
    localparam int unsigned NUM_PHYS_REGS_DEF = 64;
    localparam int unsigned AL_DEPTH_DEF      = 32;
    localparam int unsigned NUM_CKPT_DEF      = 4;

    localparam int unsigned ARCH_W = $clog2(NUM_ARCH_REGS_DEF);
    localparam int unsigned PHYS_W = $clog2(NUM_PHYS_REGS_DEF);

    typedef logic [ARCH_W-1:0] ArchReg;
    typedef logic [PHYS_W-1:0] PhysReg;

    // Active-list entry: the mapping displaced by this instruction and
    // whether it must be returned to the free list at commit.
    typedef struct packed {
        PhysReg old_phys;
        logic   do_free;
    } al_entry_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers with head snapshot/restore
// so a branch mispredict can return speculatively popped registers.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int unsigned DEPTH = NUM_PHYS_REGS_DEF - NUM_ARCH_REGS_DEF,
    parameter int unsigned FIRST = NUM_ARCH_REGS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pop_i,
    output PhysReg                  pop_data_o,
    input  logic                    push_i,
    input  PhysReg                  push_data_i,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  head_o,
    input  logic                    restore_i,
    input  logic [$clog2(DEPTH):0]  restore_head_i
);

    localparam int unsigned IW = $clog2(DEPTH);

    PhysReg     mem_q [DEPTH];
    logic [IW:0] head_q, head_d;
    logic [IW:0] tail_q, tail_d;
    logic        full;

    assign pop_data_o = mem_q[head_q[IW-1:0]];
    assign empty_o    = (head_q == tail_q);
    assign full       = (head_q[IW] != tail_q[IW]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign head_o     = head_q;

    // Pointer next-state: a restore overrides any pop; the tail is independent.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (restore_i) begin
            head_d = restore_head_i;
        end else if (pop_i) begin
            head_d = head_q + (IW+1)'(1);
        end
        if (push_i) begin
            tail_d = tail_q + (IW+1)'(1);
        end
    end

    // Storage and pointers; reset preloads FIRST..FIRST+DEPTH-1 ascending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PhysReg'(FIRST + i);
            end
            head_q <= '0;
            tail_q <= {1'b1, {IW{1'b0}}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (push_i) begin
                mem_q[tail_q[IW-1:0]] <= push_data_i;
            end
        end
    end

    a_fl_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));
    a_fl_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/rename_map_unit.sv
// Register rename stage: RMT, busy table, active list and branch
// checkpoint ring around a free-list FIFO.
module rename_map_unit
    import rename_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
    parameter int unsigned NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
    parameter int unsigned AL_DEPTH      = AL_DEPTH_DEF,
    parameter int unsigned NUM_CKPT      = NUM_CKPT_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ren_valid,
    output logic                              ren_ready,
    input  logic                              ren_uses_rs,
    input  logic                              ren_uses_rt,
    input  logic                              ren_uses_rw,
    input  logic                              ren_is_branch,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]  ren_rs_addr,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]  ren_rt_addr,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]  ren_rw_addr,
    output logic                              out_valid,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]  out_rs_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]  out_rt_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]  out_rw_phys,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]  out_old_phys,
    output logic                              out_rs_ready,
    output logic                              out_rt_ready,
    output logic [$clog2(AL_DEPTH)-1:0]       out_al_idx,
    output logic [$clog2(NUM_CKPT)-1:0]       out_ckpt_id,
    input  logic                              wb_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0]  wb_phys,
    input  logic                              commit_valid,
    input  logic                              br_valid,
    input  logic                              br_mispredict
);

    localparam int unsigned PW       = $clog2(NUM_PHYS_REGS);
    localparam int unsigned LW       = $clog2(AL_DEPTH);
    localparam int unsigned CW       = $clog2(NUM_CKPT);
    localparam int unsigned FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned FW       = $clog2(FL_DEPTH);

    typedef logic [NUM_ARCH_REGS-1:0][PW-1:0] rmt_t;

    rmt_t                   rmt_q, rmt_d;
    logic [NUM_PHYS_REGS-1:0] busy_q, busy_d;
    al_entry_t              al_mem_q [AL_DEPTH];
    logic [LW:0]            al_head_q, al_head_d, al_tail_q, al_tail_d;
    rmt_t                   ck_rmt_q [NUM_CKPT];
    logic [FW:0]            ck_fl_head_q [NUM_CKPT];
    logic [LW:0]            ck_al_tail_q [NUM_CKPT];
    logic [CW:0]            ck_head_q, ck_head_d, ck_tail_q, ck_tail_d;
    logic                   init_q;

    logic        need_dst, mispredict, accept, alloc, commit_ok, restore, br_release;
    logic        al_empty, al_full, ck_empty, ck_full, fl_empty, fl_push;
    al_entry_t   commit_entry;
    PhysReg      fl_pop_data;
    logic [FW:0] fl_head, fl_head_after;
    logic [PW-1:0] rs_phys, rt_phys, old_phys, new_phys;
    logic        rs_ready, rt_ready;

    assign need_dst   = ren_uses_rw && (ren_rw_addr != '0);
    assign mispredict = br_valid && br_mispredict;
    assign al_empty   = (al_head_q == al_tail_q);
    assign al_full    = (al_head_q[LW] != al_tail_q[LW]) && (al_head_q[LW-1:0] == al_tail_q[LW-1:0]);
    assign ck_empty   = (ck_head_q == ck_tail_q);
    assign ck_full    = (ck_head_q[CW] != ck_tail_q[CW]) && (ck_head_q[CW-1:0] == ck_tail_q[CW-1:0]);

    assign ren_ready  = init_q && (!need_dst || !fl_empty) && !al_full
                        && (!ren_is_branch || !ck_full) && !mispredict;
    assign accept     = ren_valid && ren_ready;
    assign alloc      = accept && need_dst;
    assign commit_ok  = commit_valid && !al_empty;
    assign commit_entry = al_mem_q[al_head_q[LW-1:0]];
    assign fl_push    = commit_ok && commit_entry.do_free;
    assign restore    = mispredict && !ck_empty;
    assign br_release = br_valid && !br_mispredict && !ck_empty;
    assign fl_head_after = fl_head + (FW+1)'(alloc);

    rename_free_list #(
        .DEPTH (FL_DEPTH),
        .FIRST (NUM_ARCH_REGS)
    ) u_free_list (
        .clk            (clk),
        .rst_n          (rst_n),
        .pop_i          (alloc),
        .pop_data_o     (fl_pop_data),
        .push_i         (fl_push),
        .push_data_i    (commit_entry.old_phys),
        .empty_o        (fl_empty),
        .head_o         (fl_head),
        .restore_i      (restore),
        .restore_head_i (ck_fl_head_q[ck_head_q[CW-1:0]])
    );

    // Source lookup against the pre-update RMT, with writeback bypass on readiness.
    always_comb begin
        rs_phys  = ren_uses_rs ? rmt_q[ren_rs_addr] : '0;
        rt_phys  = ren_uses_rt ? rmt_q[ren_rt_addr] : '0;
        rs_ready = !ren_uses_rs || !busy_q[rs_phys] || (wb_valid && (wb_phys == rs_phys));
        rt_ready = !ren_uses_rt || !busy_q[rt_phys] || (wb_valid && (wb_phys == rt_phys));
        new_phys = need_dst ? fl_pop_data : '0;
        old_phys = need_dst ? rmt_q[ren_rw_addr] : '0;
    end

    // Next-state for map, busy table, active-list and checkpoint-ring pointers.
    always_comb begin
        rmt_d     = rmt_q;
        busy_d    = busy_q;
        al_head_d = al_head_q;
        al_tail_d = al_tail_q;
        ck_head_d = ck_head_q;
        ck_tail_d = ck_tail_q;
        if (restore) begin
            rmt_d = ck_rmt_q[ck_head_q[CW-1:0]];
        end else if (alloc) begin
            rmt_d[ren_rw_addr] = fl_pop_data;
        end
        if (wb_valid) begin
            busy_d[wb_phys] = 1'b0;
        end
        if (alloc) begin
            busy_d[new_phys] = 1'b1;
        end
        if (commit_ok) begin
            al_head_d = al_head_q + (LW+1)'(1);
        end
        if (restore) begin
            al_tail_d = ck_al_tail_q[ck_head_q[CW-1:0]];
            ck_tail_d = ck_head_q;
        end else begin
            if (accept) begin
                al_tail_d = al_tail_q + (LW+1)'(1);
            end
            if (br_release) begin
                ck_head_d = ck_head_q + (CW+1)'(1);
            end
            if (accept && ren_is_branch) begin
                ck_tail_d = ck_tail_q + (CW+1)'(1);
            end
        end
    end

    // Architectural-state registers with identity map at reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
                rmt_q[i] <= PW'(i);
            end
            busy_q    <= '0;
            al_head_q <= '0;
            al_tail_q <= '0;
            ck_head_q <= '0;
            ck_tail_q <= '0;
            init_q    <= 1'b0;
        end else begin
            rmt_q     <= rmt_d;
            busy_q    <= busy_d;
            al_head_q <= al_head_d;
            al_tail_q <= al_tail_d;
            ck_head_q <= ck_head_d;
            ck_tail_q <= ck_tail_d;
            init_q    <= 1'b1;
        end
    end

    // Active-list and checkpoint payload storage; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            al_mem_q[al_tail_q[LW-1:0]] <= al_entry_t'{old_phys: old_phys, do_free: need_dst};
        end
        if (accept && ren_is_branch) begin
            ck_rmt_q[ck_tail_q[CW-1:0]]     <= rmt_d;
            ck_fl_head_q[ck_tail_q[CW-1:0]] <= fl_head_after;
            ck_al_tail_q[ck_tail_q[CW-1:0]] <= al_tail_q + (LW+1)'(1);
        end
    end

    // Registered rename result, one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_rs_phys  <= '0;
            out_rt_phys  <= '0;
            out_rw_phys  <= '0;
            out_old_phys <= '0;
            out_rs_ready <= 1'b0;
            out_rt_ready <= 1'b0;
            out_al_idx   <= '0;
            out_ckpt_id  <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_rs_phys  <= rs_phys;
                out_rt_phys  <= rt_phys;
                out_rw_phys  <= new_phys;
                out_old_phys <= old_phys;
                out_rs_ready <= rs_ready;
                out_rt_ready <= rt_ready;
                out_al_idx   <= al_tail_q[LW-1:0];
                out_ckpt_id  <= ren_is_branch ? ck_tail_q[CW-1:0] : '0;
            end
        end
    end

    a_commit_empty: assert property (@(posedge clk) disable iff (!rst_n) !(commit_valid && al_empty));
    a_al_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(accept && al_full));
    a_resolve_empty: assert property (@(posedge clk) disable iff (!rst_n) !(br_valid && ck_empty));

endmodule

// File: tb/tb_rename_map_unit.sv
// Randomized self-checking bench for rename_map_unit against a queue-based
// reference model of renaming, commit and checkpoint recovery.
module tb_rename_map_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ren_valid, ren_ready;
    logic       ren_uses_rs, ren_uses_rt, ren_uses_rw, ren_is_branch;
    logic [4:0] ren_rs_addr, ren_rt_addr, ren_rw_addr;
    logic       out_valid;
    logic [5:0] out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys;
    logic       out_rs_ready, out_rt_ready;
    logic [4:0] out_al_idx;
    logic [1:0] out_ckpt_id;
    logic       wb_valid;
    logic [5:0] wb_phys;
    logic       commit_valid, br_valid, br_mispredict;

    always #5 clk = ~clk;

    rename_map_unit #(
        .NUM_ARCH_REGS (32),
        .NUM_PHYS_REGS (64),
        .AL_DEPTH      (32),
        .NUM_CKPT      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ren_valid     (ren_valid),
        .ren_ready     (ren_ready),
        .ren_uses_rs   (ren_uses_rs),
        .ren_uses_rt   (ren_uses_rt),
        .ren_uses_rw   (ren_uses_rw),
        .ren_is_branch (ren_is_branch),
        .ren_rs_addr   (ren_rs_addr),
        .ren_rt_addr   (ren_rt_addr),
        .ren_rw_addr   (ren_rw_addr),
        .out_valid     (out_valid),
        .out_rs_phys   (out_rs_phys),
        .out_rt_phys   (out_rt_phys),
        .out_rw_phys   (out_rw_phys),
        .out_old_phys  (out_old_phys),
        .out_rs_ready  (out_rs_ready),
        .out_rt_ready  (out_rt_ready),
        .out_al_idx    (out_al_idx),
        .out_ckpt_id   (out_ckpt_id),
        .wb_valid      (wb_valid),
        .wb_phys       (wb_phys),
        .commit_valid  (commit_valid),
        .br_valid      (br_valid),
        .br_mispredict (br_mispredict)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { int old_p; bit fr; int seq; } ale_t;
    typedef struct packed { logic [31:0][5:0] rmt; int nalloc; int seq; } ck_t;

    int   m_rmt [32];
    bit   m_busy [64];
    int   m_fl [$];
    int   m_hist [$];   // every phys handed out since reset, in order
    ale_t m_al [$];
    ck_t  m_ck [$];
    int   m_al_head_slot, m_ck_head_slot, m_seq;
    bit   m_init;
    logic last_ready;

    typedef struct {
        bit v, urs, urt, urw, br;
        int rs, rt, rw;
        bit wbv;
        int wbp;
        bit cm, bv, bm;
    } stim_t;

    function automatic stim_t mk(bit v, bit urs, int rs, bit urt, int rt, bit urw, int rw, bit br);
        stim_t s;
        s.v = v; s.urs = urs; s.rs = rs; s.urt = urt; s.rt = rt;
        s.urw = urw; s.rw = rw; s.br = br;
        s.wbv = 0; s.wbp = 0; s.cm = 0; s.bv = 0; s.bm = 0;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rmt[i] = i;
        for (int i = 0; i < 64; i++) m_busy[i] = 0;
        m_fl.delete();
        for (int i = 32; i < 64; i++) m_fl.push_back(i);
        m_hist.delete();
        m_al.delete();
        m_ck.delete();
        m_al_head_slot = 0;
        m_ck_head_slot = 0;
        m_seq = 0;
        m_init = 0;
    endtask

    function automatic bit commit_legal();
        if (m_al.size() == 0) return 0;
        if (m_ck.size() == 0) return 1;
        return m_al[0].seq <= m_ck[0].seq;
    endfunction

    task automatic drive_idle();
        ren_valid = 0; ren_uses_rs = 0; ren_uses_rt = 0; ren_uses_rw = 0; ren_is_branch = 0;
        ren_rs_addr = '0; ren_rt_addr = '0; ren_rw_addr = '0;
        wb_valid = 0; wb_phys = '0; commit_valid = 0; br_valid = 0; br_mispredict = 0;
    endtask

    // Called at a falling edge: drive, check ready, advance model, check outputs.
    task automatic do_cycle(input stim_t s);
        bit need, misp, exp_rdy, acc;
        int e_rs, e_rt, e_rw, e_old, e_al, e_ck, p;
        bit e_rs_rdy, e_rt_rdy;
        ale_t e;
        ck_t c;
        ren_valid = s.v; ren_uses_rs = s.urs; ren_uses_rt = s.urt; ren_uses_rw = s.urw;
        ren_is_branch = s.br; ren_rs_addr = 5'(s.rs); ren_rt_addr = 5'(s.rt); ren_rw_addr = 5'(s.rw);
        wb_valid = s.wbv; wb_phys = 6'(s.wbp); commit_valid = s.cm;
        br_valid = s.bv; br_mispredict = s.bm;
        #1;
        need    = s.urw && (s.rw != 0);
        misp    = s.bv && s.bm;
        exp_rdy = m_init && (!need || m_fl.size() > 0) && (m_al.size() < 32)
                  && (!s.br || m_ck.size() < 4) && !misp;
        last_ready = ren_ready;
        check_eq("ren_ready", ren_ready, exp_rdy);
        acc = s.v && exp_rdy;

        e_rs = s.urs ? m_rmt[s.rs] : 0;
        e_rt = s.urt ? m_rmt[s.rt] : 0;
        e_rs_rdy = !s.urs || !m_busy[e_rs] || (s.wbv && s.wbp == e_rs);
        e_rt_rdy = !s.urt || !m_busy[e_rt] || (s.wbv && s.wbp == e_rt);
        e_rw  = (acc && need) ? m_fl[0] : 0;
        e_old = need ? m_rmt[s.rw] : 0;
        e_al  = (m_al_head_slot + m_al.size()) % 32;
        e_ck  = (m_ck_head_slot + m_ck.size()) % 4;

        if (s.wbv) m_busy[s.wbp] = 0;
        if (acc) begin
            if (need) begin
                p = m_fl.pop_front();
                m_hist.push_back(p);
                m_busy[p] = 1;
                m_rmt[s.rw] = p;
            end
            m_al.push_back('{old_p: e_old, fr: need, seq: m_seq});
            if (s.br) begin
                for (int i = 0; i < 32; i++) c.rmt[i] = 6'(m_rmt[i]);
                c.nalloc = m_hist.size();
                c.seq = m_seq;
                m_ck.push_back(c);
            end
            m_seq++;
        end
        if (s.cm && m_al.size() > 0) begin
            e = m_al.pop_front();
            m_al_head_slot = (m_al_head_slot + 1) % 32;
            if (e.fr) m_fl.push_back(e.old_p);
        end
        if (s.bv && m_ck.size() > 0) begin
            if (s.bm) begin
                c = m_ck[0];
                for (int i = 0; i < 32; i++) m_rmt[i] = int'(c.rmt[i]);
                for (int i = m_hist.size() - 1; i >= c.nalloc; i--) m_fl.push_front(m_hist[i]);
                while (m_hist.size() > c.nalloc) void'(m_hist.pop_back());
                while (m_al.size() > 0 && m_al[$].seq > c.seq) void'(m_al.pop_back());
                m_ck.delete();
            end else begin
                void'(m_ck.pop_front());
                m_ck_head_slot = (m_ck_head_slot + 1) % 4;
            end
        end

        @(posedge clk);
        #1;
        m_init = 1;
        check_eq("out_valid", out_valid, acc);
        if (acc) begin
            check_eq("out_rs_phys", out_rs_phys, e_rs);
            check_eq("out_rt_phys", out_rt_phys, e_rt);
            check_eq("out_rs_ready", out_rs_ready, e_rs_rdy);
            check_eq("out_rt_ready", out_rt_ready, e_rt_rdy);
            check_eq("out_rw_phys", out_rw_phys, e_rw);
            check_eq("out_old_phys", out_old_phys, e_old);
            check_eq("out_al_idx", out_al_idx, e_al);
            if (s.br) check_eq("out_ckpt_id", out_ckpt_id, e_ck);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; all outputs must clear at once.
    task automatic apply_reset();
        drive_idle();
        ren_valid = 1;
        rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_ren_ready", ren_ready, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_rw_phys", out_rw_phys, 0);
            check_eq("rst_out_old_phys", out_old_phys, 0);
            check_eq("rst_out_rs_phys", out_rs_phys, 0);
            check_eq("rst_out_al_idx", out_al_idx, 0);
            check_eq("rst_out_rs_ready", out_rs_ready, 0);
            @(negedge clk);
        end
        drive_idle();
        rst_n = 1;
        model_reset();
    endtask

    stim_t s;

    initial begin
        rst_n = 1;
        drive_idle();
        model_reset();
        @(negedge clk);
        apply_reset();

        // first cycle after reset: not ready
        do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));

        // destination r0: no allocation, nothing freed at commit
        do_cycle(mk(1, 0, 0, 0, 0, 1, 0, 0));
        check_eq("r0_rw_phys", out_rw_phys, 0);
        check_eq("r0_old_phys", out_old_phys, 0);
        s = mk(0, 0, 0, 0, 0, 0, 0, 0); s.cm = 1;
        do_cycle(s);

        // three renames of r5 from a fresh free list
        do_cycle(mk(1, 0, 0, 0, 0, 1, 5, 0));
        check_eq("r5a_rw", out_rw_phys, 32);
        check_eq("r5a_old", out_old_phys, 5);
        do_cycle(mk(1, 0, 0, 0, 0, 1, 5, 0));
        check_eq("r5b_rw", out_rw_phys, 33);
        check_eq("r5b_old", out_old_phys, 32);
        do_cycle(mk(1, 0, 0, 0, 0, 1, 5, 0));
        check_eq("r5c_rw", out_rw_phys, 34);
        check_eq("r5c_old", out_old_phys, 33);

        // busy source, then same-cycle writeback bypass
        do_cycle(mk(1, 0, 0, 0, 0, 1, 3, 0));
        check_eq("r3_rw", out_rw_phys, 35);
        do_cycle(mk(1, 1, 3, 0, 0, 0, 0, 0));
        check_eq("rs3_busy_phys", out_rs_phys, 35);
        check_eq("rs3_busy_rdy", out_rs_ready, 0);
        s = mk(1, 1, 3, 0, 0, 0, 0, 0); s.wbv = 1; s.wbp = 35;
        do_cycle(s);
        check_eq("rs3_bypass_rdy", out_rs_ready, 1);

        // branch, speculative rename, mispredict recovery
        do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1));
        do_cycle(mk(1, 0, 0, 0, 0, 1, 7, 0));
        check_eq("spec_r7_rw", out_rw_phys, 36);
        s = mk(0, 0, 0, 0, 0, 0, 0, 0); s.bv = 1; s.bm = 1;
        do_cycle(s);
        do_cycle(mk(1, 0, 0, 0, 0, 1, 7, 0));
        check_eq("rec_r7_rw", out_rw_phys, 36);
        check_eq("rec_r7_old", out_old_phys, 7);

        // reset in the middle of activity
        do_cycle(mk(1, 1, 7, 0, 0, 1, 8, 0));
        apply_reset();
        do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // fill the active list, then free one entry
        for (int i = 0; i < 32; i++) do_cycle(mk(1, 0, 0, 0, 0, 1, (i % 31) + 1, 0));
        do_cycle(mk(1, 0, 0, 0, 0, 1, 9, 0));
        check_eq("full_stall", last_ready, 0);
        s = mk(1, 0, 0, 0, 0, 1, 9, 0); s.cm = 1;
        do_cycle(s);
        do_cycle(mk(1, 0, 0, 0, 0, 1, 9, 0));
        check_eq("after_commit_ready", last_ready, 1);
        check_eq("after_commit_rw", out_rw_phys, 1);

        // commit + writeback + mispredict in one cycle
        for (int i = 0; i < 3; i++) begin
            s = mk(0, 0, 0, 0, 0, 0, 0, 0); s.cm = 1;
            do_cycle(s);
        end
        do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1));
        do_cycle(mk(1, 0, 0, 0, 0, 1, 4, 0));
        check_eq("pre_misp_rw", out_rw_phys, 2);
        s = mk(1, 0, 0, 0, 0, 1, 5, 0); s.cm = 1; s.wbv = 1; s.wbp = 2; s.bv = 1; s.bm = 1;
        do_cycle(s);
        check_eq("triple_stall", last_ready, 0);
        check_eq("triple_no_out", out_valid, 0);
        do_cycle(mk(1, 1, 4, 0, 0, 1, 4, 0));
        check_eq("triple_rw_restored", out_rw_phys, 2);
        check_eq("triple_old_restored", out_old_phys, 35);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                apply_reset();
            end
            s = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 31),
                   $urandom_range(0, 1), $urandom_range(0, 31),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 4) == 0);
            s.wbv = $urandom_range(0, 1);
            s.wbp = $urandom_range(0, 63);
            s.cm  = commit_legal() && ($urandom_range(0, 9) < 4);
            s.bv  = (m_ck.size() > 0) && ($urandom_range(0, 4) == 0);
            s.bm  = s.bv && ($urandom_range(0, 9) < 3);
            do_cycle(s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
